// File: rtl/led_pattern_ctrl_if.sv
// rtl/led_pattern_ctrl_if.sv - switch/button inputs and LED bank outputs of the LED pattern controller
interface led_pattern_ctrl_if #(
  parameter int NB_LEDS = 4,
  parameter int NB_SW   = 4
);
  logic [NB_SW-1:0]   i_sw;
  logic [NB_SW-1:0]   i_btn;
  logic [NB_LEDS-1:0] o_led;
  logic [NB_LEDS-1:0] o_led_r;
  logic [NB_LEDS-1:0] o_led_g;
  logic [NB_LEDS-1:0] o_led_b;

  modport master (
    output i_sw, i_btn,
    input  o_led, o_led_r, o_led_g, o_led_b
  );

  modport slave (
    input  i_sw, i_btn,
    output o_led, o_led_r, o_led_g, o_led_b
  );
endinterface

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - prescaled rotate/flash LED pattern routed to one of three colour banks
// Optional LED_BTN_SYNC_EN: 2-flop synchronizer on each button ahead of edge detection.
module led_pattern_ctrl #(
  parameter int NB_LEDS    = 4,
  parameter int NB_COUNTER = 14,
  parameter int NB_SW      = 4
) (
  input logic              clock,
  input logic              i_reset,
  led_pattern_ctrl_if.slave bus
);

  typedef enum logic {SHIFT = 1'b0, FLASH = 1'b1} mode_e;
  typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, BLUE = 2'd2} colour_e;

  localparam logic [NB_COUNTER-1:0] LIM_FULL = '1;
  localparam logic [NB_LEDS-1:0]    PAT_INIT = NB_LEDS'(1);

  mode_e                 mode_q, mode_d;
  colour_e               colour_q, colour_d;
  logic [NB_COUNTER-1:0] counter_q, counter_d;
  logic [NB_LEDS-1:0]    pattern_q, pattern_d;
  logic [NB_SW-1:0]      btn_hist_q, btn_hist_d;
  logic [NB_SW-1:0]      btn_in;
  logic [NB_SW-1:0]      rise;
  logic [NB_COUNTER-1:0] limit;
  logic                  tick;

`ifdef LED_BTN_SYNC_EN
  logic [NB_SW-1:0] sync1_q, sync1_d;
  logic [NB_SW-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.i_btn;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign btn_in = sync2_q;
`else
  assign btn_in = bus.i_btn;
`endif

  always_comb begin
    case (bus.i_sw[2:1])
      2'b00:   limit = LIM_FULL;
      2'b01:   limit = LIM_FULL >> 1;
      2'b10:   limit = LIM_FULL >> 2;
      default: limit = LIM_FULL >> 3;
    endcase
  end

  always_comb begin
    tick      = 1'b0;
    counter_d = counter_q;
    // >= rather than == so a limit lowered mid-count wraps at once
    if (bus.i_sw[0]) begin
      if (counter_q >= limit) begin
        counter_d = '0;
        tick      = 1'b1;
      end else begin
        counter_d = counter_q + NB_COUNTER'(1);
      end
    end

    rise       = btn_in & ~btn_hist_q;
    btn_hist_d = btn_in;

    mode_d    = mode_q;
    pattern_d = pattern_q;
    if (rise[0]) begin
      if (mode_q == SHIFT) begin
        mode_d    = FLASH;
        pattern_d = '1;
      end else begin
        mode_d    = SHIFT;
        pattern_d = PAT_INIT;
      end
    end else if (tick) begin
      if (mode_q == FLASH)
        pattern_d = ~pattern_q;
      else if (bus.i_sw[3])
        pattern_d = {pattern_q[0], pattern_q[NB_LEDS-1:1]};
      else
        pattern_d = {pattern_q[NB_LEDS-2:0], pattern_q[NB_LEDS-1]};
    end

    colour_d = colour_q;
    if (rise[1])
      colour_d = RED;
    else if (rise[2])
      colour_d = GREEN;
    else if (rise[3])
      colour_d = BLUE;
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      mode_q     <= SHIFT;
      colour_q   <= RED;
      counter_q  <= '0;
      pattern_q  <= PAT_INIT;
      btn_hist_q <= '0;
    end else begin
      mode_q     <= mode_d;
      colour_q   <= colour_d;
      counter_q  <= counter_d;
      pattern_q  <= pattern_d;
      btn_hist_q <= btn_hist_d;
    end
  end

  assign bus.o_led_r = (colour_q == RED)   ? pattern_q : '0;
  assign bus.o_led_g = (colour_q == GREEN) ? pattern_q : '0;
  assign bus.o_led_b = (colour_q == BLUE)  ? pattern_q : '0;
  assign bus.o_led   = NB_LEDS'({colour_q == BLUE, colour_q == GREEN,
                                 colour_q == RED, mode_q == FLASH});

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - directed self-checking bench for led_pattern_ctrl
module tb_led_pattern_ctrl;

`ifdef LED_BTN_SYNC_EN
  localparam int BTN_LAT = 3;
`else
  localparam int BTN_LAT = 1;
`endif

  logic clock = 1'b0;
  logic i_reset;
  int   tests = 0;
  int   fails = 0;
  int   cnt   = 0;

  led_pattern_ctrl_if #(.NB_LEDS(4), .NB_SW(4)) bus ();

  led_pattern_ctrl dut (
    .clock  (clock),
    .i_reset(i_reset),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  function automatic int lim_of(input logic [3:0] sw);
    case (sw[2:1])
      2'b00:   return 16383;
      2'b01:   return 8191;
      2'b10:   return 4095;
      default: return 2047;
    endcase
  endfunction

  // Advances n clock edges, tracking the prescaler count; samples 1ns after each edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      if (i_reset)
        cnt = 0;
      else if (bus.i_sw[0]) begin
        if (cnt >= lim_of(bus.i_sw)) cnt = 0;
        else cnt++;
      end
      #1;
    end
  endtask

  // Leaves the bench one edge before the next tick edge.
  task automatic run_to_tick();
    step(lim_of(bus.i_sw) - cnt);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] led, input logic [3:0] r,
                         input logic [3:0] g, input logic [3:0] b);
    chk({tag, ".led"}, bus.o_led, led);
    chk({tag, ".r"}, bus.o_led_r, r);
    chk({tag, ".g"}, bus.o_led_g, g);
    chk({tag, ".b"}, bus.o_led_b, b);
  endtask

  initial begin
    i_reset    = 1'b1;
    bus.i_sw   = 4'b0000;
    bus.i_btn  = 4'b0000;
    step(3);
    chk_all("reset", 4'b0010, 4'b0001, 4'b0000, 4'b0000);
    i_reset = 1'b0;
    cnt     = 0;
    step(100);
    chk_all("idle", 4'b0010, 4'b0001, 4'b0000, 4'b0000);

    // rotate left at 2048-cycle ticks
    bus.i_sw = 4'b0111;
    step(2047);
    chk("shl_hold", bus.o_led_r, 4'b0001);
    step(1);
    chk("shl1", bus.o_led_r, 4'b0010);
    step(2048);
    chk("shl2", bus.o_led_r, 4'b0100);
    step(2048);
    chk("shl3", bus.o_led_r, 4'b1000);
    step(2048);
    chk("shl_wrap", bus.o_led_r, 4'b0001);
    bus.i_sw = 4'b1111;
    run_to_tick();
    step(1);
    chk("shr", bus.o_led_r, 4'b1000);

    // flash mode via a 3-cycle btn0 pulse
    bus.i_btn = 4'b0001;
    step(BTN_LAT);
    chk_all("flash_on", 4'b0011, 4'b1111, 4'b0000, 4'b0000);
    step(3 - BTN_LAT);
    bus.i_btn = 4'b0000;
    run_to_tick();
    chk("flash_hold", bus.o_led_r, 4'b1111);
    step(1);
    chk("flash_inv", bus.o_led_r, 4'b0000);
    run_to_tick();
    step(1);
    chk("flash_inv2", bus.o_led_r, 4'b1111);
    bus.i_btn = 4'b0001;
    step(BTN_LAT);
    chk_all("shift_back", 4'b0010, 4'b0001, 4'b0000, 4'b0000);
    step(3 - BTN_LAT);
    bus.i_btn = 4'b0000;
    step(BTN_LAT + 1);

    // colour selection and priority
    bus.i_btn = 4'b0100;
    step(BTN_LAT);
    chk_all("green", 4'b0100, 4'b0000, 4'b0001, 4'b0000);
    bus.i_btn = 4'b0000;
    step(BTN_LAT + 1);
    bus.i_btn = 4'b1000;
    step(BTN_LAT);
    chk_all("blue", 4'b1000, 4'b0000, 4'b0000, 4'b0001);
    bus.i_btn = 4'b0000;
    step(BTN_LAT + 1);
    bus.i_btn = 4'b1100;
    step(BTN_LAT);
    chk_all("g_over_b", 4'b0100, 4'b0000, 4'b0001, 4'b0000);
    bus.i_btn = 4'b0000;
    step(BTN_LAT + 1);
    bus.i_btn = 4'b1010;
    step(BTN_LAT);
    chk_all("r_over_b", 4'b0010, 4'b0001, 4'b0000, 4'b0000);
    bus.i_btn = 4'b0000;
    step(BTN_LAT + 1);

    // held button acts once, release does nothing
    bus.i_btn = 4'b0001;
    step(BTN_LAT);
    chk("hold_act", bus.o_led, 4'b0011);
    step(10);
    chk("hold_once", bus.o_led, 4'b0011);
    bus.i_btn = 4'b0000;
    step(BTN_LAT + 1);
    chk("release", bus.o_led, 4'b0011);
    bus.i_btn = 4'b0001;
    step(BTN_LAT);
    chk_all("hold_back", 4'b0010, 4'b0001, 4'b0000, 4'b0000);
    bus.i_btn = 4'b0000;
    step(BTN_LAT + 1);

    // btn0 rise detected on the tick edge: the load wins
    step(lim_of(bus.i_sw) - cnt + 1 - BTN_LAT);
    bus.i_btn = 4'b0001;
    step(BTN_LAT);
    chk_all("collide", 4'b0011, 4'b1111, 4'b0000, 4'b0000);
    bus.i_btn = 4'b0000;
    run_to_tick();
    step(1);
    chk("post_collide", bus.o_led_r, 4'b0000);
    bus.i_btn = 4'b1000;
    step(BTN_LAT);
    chk_all("flash_blue", 4'b1001, 4'b0000, 4'b0000, 4'b0000);
    bus.i_btn = 4'b0000;
    step(BTN_LAT + 1);

    // 16384-cycle period, freeze and resume
    bus.i_sw = 4'b0001;
    run_to_tick();
    step(1);
    chk("p16k_tick", bus.o_led_b, 4'b1111);
    step(16383);
    chk("p16k_full_hold", bus.o_led_b, 4'b1111);
    step(1);
    chk("p16k_full", bus.o_led_b, 4'b0000);
    step(2000);
    bus.i_sw = 4'b0000;
    step(3000);
    chk("frozen", bus.o_led_b, 4'b0000);
    bus.i_sw = 4'b0001;
    run_to_tick();
    chk("resume_hold", bus.o_led_b, 4'b0000);
    step(1);
    chk("resume_tick", bus.o_led_b, 4'b1111);

    // limit lowered below the running count wraps on the next edge
    step(3000);
    bus.i_sw = 4'b0111;
    step(1);
    chk("lim_lower", bus.o_led_b, 4'b0000);

    // asynchronous reset mid-count in FLASH/BLUE
    step(100);
    i_reset = 1'b1;
    #2;
    chk_all("async_reset", 4'b0010, 4'b0001, 4'b0000, 4'b0000);
    step(2);
    i_reset = 1'b0;
    run_to_tick();
    chk("post_rst_hold", bus.o_led_r, 4'b0001);
    step(1);
    chk("post_rst_tick", bus.o_led_r, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
LED pattern controller for the board-level LED demo. A free-running prescaler counter generates a tick, and its period is selectable by switches. On each tick a 4-bit pattern either rotates (shift mode) or blinks (flash mode). The pattern is routed to one of three RGB LED banks, and a status LED bank shows the current mode and colour.

Parameters:
- NB_LEDS, 4, width of the pattern and of each LED bank.
- NB_COUNTER, 14, prescaler counter width.
- NB_SW, 4, width of the switch and button buses.

Ports:
- clock  in  1  system clock; all state is on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_sw  in  NB_SW
  - [0] counter enable
  - [2:1] tick period select
  - [3] shift direction
- i_btn  in  NB_SW
  - [0] mode toggle
  - [1] select red
  - [2] select green
  - [3] select blue
- o_led  in/out: out  NB_LEDS  status bank: [0] mode (1 = flash), [1] red selected, [2] green selected, [3] blue selected.
- o_led_r  out  NB_LEDS  red bank.
- o_led_g  out  NB_LEDS  green bank.
- o_led_b  out  NB_LEDS  blue bank.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - counter = 0
  - mode = SHIFT
  - pattern = 0001
  - colour = RED
  - button history registers = 0
  - After reset: o_led = 0010, o_led_r = 0001, o_led_g = 0000, o_led_b = 0000.
- Prescaler:
  - Limit by i_sw[2:1]:
    - 00 -> 2^NB_COUNTER-1 (16383)
    - 01 -> 2^(NB_COUNTER-1)-1 (8191)
    - 10 -> 2^(NB_COUNTER-2)-1 (4095)
    - 11 -> 2^(NB_COUNTER-3)-1 (2047)
  - While i_sw[0] = 1: if counter >= limit, counter <= 0 and tick = 1 for one cycle; otherwise counter + 1.
  - The >= comparison covers a limit lowered mid-count: the counter wraps on the next enabled cycle.
  - While i_sw[0] = 0: counter holds, no ticks, pattern frozen.
  - Tick period = limit + 1 cycles.
- Button edge detection:
  - Each button bit is registered every cycle.
  - Rising edge = raw & ~registered.
  - The action takes effect at the clock edge where the edge is detected; the resulting output is visible 1 cycle after the button goes high.
  - A held button acts once. Release has no effect.
- Mode state machine, two states:
  - SHIFT -> FLASH on a btn0 rise; pattern loaded to 1111.
  - FLASH -> SHIFT on a btn0 rise; pattern loaded to 0001.
  - A btn0 rise on the same cycle as a tick: the mode change/load wins and the tick is ignored for the pattern.
- Pattern update on tick:
  - SHIFT, i_sw[3] = 0: rotate left (0001 -> 0010 -> 0100 -> 1000 -> 0001).
  - SHIFT, i_sw[3] = 1: rotate right (0001 -> 1000 -> 0100 -> ...).
  - A direction change applies at the next tick; the pattern is not reloaded.
  - FLASH: pattern inverted (1111 <-> 0000).
- Colour select:
  - A rise on btn1 / btn2 / btn3 selects RED / GREEN / BLUE.
  - Simultaneous rises resolve with priority btn1 > btn2 > btn3.
  - Colour is independent of mode and is retained across mode changes.
- Outputs (registered-state driven, no combinational path from i_btn):
  - The selected bank = pattern; the other two banks = 0.
  - o_led = {blue_sel, green_sel, red_sel, mode}.
- Reset asserted mid-operation immediately forces all reset values; counting resumes from 0 after release.

Optional Feature:
- Macro: LED_BTN_SYNC_EN.
- Defined: each i_btn bit passes through a 2-flop synchronizer before the edge-detect register. Button action latency becomes 3 cycles from the raw rise to the output change. Synchronizer flops reset to 0.
- Undefined: no synchronizer; 1-cycle latency as specified above.

Test Plan:
- Reset then release with i_sw = 0000 and i_btn = 0000 -> o_led = 0010, o_led_r = 0001, other banks 0, stable indefinitely (counter disabled).
- i_sw = 0111 (enable, sel 11, left) -> o_led_r steps 0001 -> 0010 -> 0100 -> 1000 -> 0001, one step every 2048 cycles. Set i_sw[3] = 1 -> the next tick goes to the right neighbour.
- Pulse btn0 high for 3 cycles -> within 1 cycle: o_led[0] = 1, o_led_r = 1111; then 0000/1111 alternate every 2048 cycles. Second btn0 pulse -> SHIFT, o_led_r = 0001.
- Pulse btn2 -> o_led = {0,1,0,mode}; pattern moves to o_led_g; o_led_r = o_led_b = 0. btn1 and btn3 pressed together -> RED selected.
- i_sw[2:1] = 00 -> tick period 16384 cycles. Drop i_sw[0] mid-period -> pattern frozen; raise again -> counting resumes from the held count.
- Assert i_reset while in FLASH/BLUE with the counter mid-count -> outputs immediately return to the reset values with no clock edge required. With LED_BTN_SYNC_EN defined, repeat the btn0 test -> the mode changes 3 cycles after the raw rise.
